// File: rtl/bcd_run_controller.sv
// bcd_run_controller
//   Start/pause/clear sequencer for the two-digit BCD display counter.
//   A built-in prescaler turns CLOCK_50 into a one-cycle count tick.
//   The digits count up from 00 or down from MAX_COUNT, in packed BCD.
//
// Parameters
//   TICK_DIV   CLOCK_50 cycles per count tick (>= 2)
//   MAX_COUNT  terminal value, decimal 1..99
//
// Ports
//   CLOCK_50    in   system clock; all logic is on posedge
//   KEY0        in   synchronous reset, active-high
//   start_stop  in   button level; a rising edge is one start/pause command
//   clear       in   button level; a rising edge returns the counter to IDLE
//   dir         in   0 = up from 00, 1 = down from MAX_COUNT (used only in IDLE)
//   bcd_ones    out  ones digit, 0..9
//   bcd_tens    out  tens digit, 0..9
//   tick        out  one-cycle pulse, high in the same cycle as the new digits
//   running     out  high while counting
//   done        out  high once the terminal value has been reached
//
// Build option
//   AUTO_RELOAD_EN  When defined, the counter wraps at the terminal value
//                   instead of stopping: up goes MAX_COUNT -> 00 and down
//                   goes 00 -> MAX_COUNT. The counter stays in RUN, and done
//                   is tied low.
module bcd_run_controller #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int MAX_COUNT = 20
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       dir,
  output logic [3:0] bcd_ones,
  output logic [3:0] bcd_tens,
  output logic       tick,
  output logic       running,
  output logic       done
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]    MAX_ONES   = 4'(MAX_COUNT % 10);
  localparam logic [3:0]    MAX_TENS   = 4'(MAX_COUNT / 10);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state, state_nx;
  logic [7:0]    digits, digits_nx;
  logic [PW-1:0] presc, presc_nx;
  logic          dir_lat, dir_nx;
  logic          tick_q, tick_nx;
  logic          start_stop_p0, clear_p0;
  logic          start_cmd, clear_cmd;

  // Packed {tens, ones} value the counter starts from for a given direction.
  function automatic logic [7:0] start_value(input logic down);
    return down ? {MAX_TENS, MAX_ONES} : 8'h00;
  endfunction

  // Value at which counting stops (or wraps) for a given direction.
  function automatic logic is_terminal(input logic [7:0] v, input logic down);
    return down ? (v == 8'h00) : (v == {MAX_TENS, MAX_ONES});
  endfunction

  // One BCD step. A carry or borrow passes from ones into tens at 9 <-> 0.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic down);
    logic [3:0] o;
    logic [3:0] t;
    o = v[3:0];
    t = v[7:4];
    if (!down) begin
      if (o == 4'd9) begin
        o = 4'd0;
        t = t + 4'd1;
      end else begin
        o = o + 4'd1;
      end
    end else begin
      if (o == 4'd0) begin
        o = 4'd9;
        t = t - 4'd1;
      end else begin
        o = o - 4'd1;
      end
    end
    return {t, o};
  endfunction

  assign start_cmd = start_stop & ~start_stop_p0;
  assign clear_cmd = clear & ~clear_p0;

  always_comb begin
    state_nx  = state;
    digits_nx = digits;
    presc_nx  = presc;
    dir_nx    = dir_lat;
    tick_nx   = 1'b0;

    if (clear_cmd) begin
      state_nx  = IDLE;
      digits_nx = start_value(dir);
      presc_nx  = '0;
    end else begin
      case (state)
        IDLE: begin
          digits_nx = start_value(dir);
          if (start_cmd) begin
            state_nx = RUN;
            dir_nx   = dir;
            presc_nx = '0;
          end
        end
        RUN: begin
          if (presc == PRESC_LAST) begin
            presc_nx = '0;
            tick_nx  = 1'b1;
`ifdef AUTO_RELOAD_EN
            digits_nx = is_terminal(digits, dir_lat) ? start_value(dir_lat)
                                                     : bcd_step(digits, dir_lat);
`else
            digits_nx = bcd_step(digits, dir_lat);
            if (is_terminal(digits_nx, dir_lat)) begin
              state_nx = DONE;
            end
`endif
          end else begin
            presc_nx = presc + 1'b1;
          end
          // A pause in the same cycle still applies that cycle's tick.
          // Landing on the terminal value takes precedence over the pause.
          if (start_cmd && (state_nx == RUN)) begin
            state_nx = PAUSE;
          end
        end
        PAUSE: begin
          if (start_cmd) begin
            state_nx = RUN;
          end
        end
        DONE: begin
          if (start_cmd) begin
            state_nx  = RUN;
            digits_nx = start_value(dir_lat);
            presc_nx  = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Stage p0: button history, state, and registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (KEY0) begin
      state         <= IDLE;
      digits        <= 8'h00;
      presc         <= '0;
      dir_lat       <= 1'b0;
      tick_q        <= 1'b0;
      start_stop_p0 <= 1'b0;
      clear_p0      <= 1'b0;
    end else begin
      state         <= state_nx;
      digits        <= digits_nx;
      presc         <= presc_nx;
      dir_lat       <= dir_nx;
      tick_q        <= tick_nx;
      start_stop_p0 <= start_stop;
      clear_p0      <= clear;
    end
  end

  assign bcd_tens = digits[7:4];
  assign bcd_ones = digits[3:0];
  assign tick     = tick_q;
  assign running  = (state == RUN);
`ifdef AUTO_RELOAD_EN
  assign done     = 1'b0;
`else
  assign done     = (state == DONE);
`endif

endmodule

// File: tb/tb_bcd_run_controller.sv
module tb_bcd_run_controller;

  localparam int TICK_DIV  = 4;
  localparam int MAX_COUNT = 20;

  logic       CLOCK_50 = 1'b0;
  logic       KEY0 = 1'b1;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] bcd_ones, bcd_tens;
  logic       tick, running, done;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  bcd_run_controller #(.TICK_DIV(TICK_DIV), .MAX_COUNT(MAX_COUNT)) dut (
    .CLOCK_50  (CLOCK_50),
    .KEY0      (KEY0),
    .start_stop(start_stop),
    .clear     (clear),
    .dir       (dir),
    .bcd_ones  (bcd_ones),
    .bcd_tens  (bcd_tens),
    .tick      (tick),
    .running   (running),
    .done      (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference model: the count is a plain integer; the modes mirror the
  // behaviour described for the counter, not any encoding inside the design.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_mode = M_IDLE;
  int m_cnt  = 0;
  int m_pre  = 0;
  bit m_dir  = 1'b0;
  bit m_tick = 1'b0;
  bit m_pss  = 1'b0;
  bit m_pclr = 1'b0;

  function automatic int start_of(input bit d);
    return d ? MAX_COUNT : 0;
  endfunction

  always @(posedge CLOCK_50) begin
    bit ss_ev, cl_ev;
    if (KEY0) begin
      m_mode = M_IDLE; m_cnt = 0; m_pre = 0; m_dir = 0; m_tick = 0;
      m_pss = 0; m_pclr = 0;
    end else begin
      ss_ev  = start_stop && !m_pss;
      cl_ev  = clear && !m_pclr;
      m_tick = 0;
      if (cl_ev) begin
        m_mode = M_IDLE; m_cnt = start_of(dir); m_pre = 0;
      end else begin
        case (m_mode)
          M_IDLE: begin
            m_cnt = start_of(dir);
            if (ss_ev) begin m_mode = M_RUN; m_dir = dir; m_pre = 0; end
          end
          M_RUN: begin
            if (m_pre == TICK_DIV - 1) begin
              m_pre  = 0;
              m_tick = 1;
`ifdef AUTO_RELOAD_EN
              if (m_cnt == start_of(!m_dir)) m_cnt = start_of(m_dir);
              else m_cnt = m_cnt + (m_dir ? -1 : 1);
`else
              m_cnt = m_cnt + (m_dir ? -1 : 1);
              if (m_cnt == start_of(!m_dir)) m_mode = M_DONE;
`endif
            end else begin
              m_pre = m_pre + 1;
            end
            if (ss_ev && m_mode == M_RUN) m_mode = M_PAUSE;
          end
          M_PAUSE: if (ss_ev) m_mode = M_RUN;
          default: if (ss_ev) begin m_mode = M_RUN; m_cnt = start_of(m_dir); m_pre = 0; end
        endcase
      end
      m_pss  = start_stop;
      m_pclr = clear;
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the active edge.
  always @(negedge CLOCK_50) begin
    logic [10:0] act, exp;
    if (chk_en) begin
      act = {bcd_tens, bcd_ones, tick, running, done};
`ifdef AUTO_RELOAD_EN
      exp = {4'(m_cnt / 10), 4'(m_cnt % 10), m_tick, (m_mode == M_RUN), 1'b0};
`else
      exp = {4'(m_cnt / 10), 4'(m_cnt % 10), m_tick, (m_mode == M_RUN), (m_mode == M_DONE)};
`endif
      n_chk++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL model_cycle t=%0t actual=%h expected=%h (tens,ones,tick,running,done)",
                 $time, act, exp);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_digits(input logic [7:0] v, input int budget);
    int k;
    k = 0;
    while ({bcd_tens, bcd_ones} !== v && k < budget) begin
      @(negedge CLOCK_50);
      k++;
    end
    check($sformatf("reach_%h", v), 32'({bcd_tens, bcd_ones} === v), 32'd1);
  endtask

  task automatic wait_tick(input int budget);
    int k;
    k = 0;
    do begin
      @(negedge CLOCK_50);
      k++;
    end while (tick !== 1'b1 && k < budget);
    check("wait_tick", 32'(tick), 32'd1);
  endtask

  task automatic press_start();
    start_stop = 1'b1;
    @(negedge CLOCK_50);
    start_stop = 1'b0;
  endtask

  task automatic press_clear();
    clear = 1'b1;
    @(negedge CLOCK_50);
    clear = 1'b0;
  endtask

  initial begin
    logic [9:0] tmask, rmask;
    logic [2:0] rsm;
    int ticks, bad;
    bit seen10, reached00;

    // 1. reset, then a held start_stop gives one RUN entry
    KEY0 = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    KEY0 = 1'b0;
    chk_en = 1'b1;
    @(negedge CLOCK_50);
    check("reset_state", 32'({bcd_tens, bcd_ones, tick, running, done}), 32'd0);
    start_stop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK_50);
      tmask[i] = tick;
      rmask[i] = running;
    end
    start_stop = 1'b0;
    check("held_start_running", 32'(rmask), 32'h3FF);
    check("tick_every_4th", 32'(tmask), 32'h110);
    check("digits_after_held", 32'({bcd_tens, bcd_ones}), 32'h02);

    // 2. up run with carries 09->10 and 19->20
    wait_digits(8'h09, 200);
    wait_tick(20);
    check("carry_09_10", 32'({bcd_tens, bcd_ones}), 32'h10);
    wait_digits(8'h19, 200);
    wait_tick(20);
    check("carry_19_20", 32'({bcd_tens, bcd_ones}), 32'h20);
`ifdef AUTO_RELOAD_EN
    // 6. wrap 20 -> 00 without leaving RUN
    check("auto_running_at_20", 32'({running, done}), 32'h2);
    wait_tick(20);
    check("auto_wrap_00", 32'({bcd_tens, bcd_ones, running, done}), 32'h002);
`else
    @(negedge CLOCK_50);
    check("done_after_20", 32'({running, done}), 32'h1);
    bad = 0;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      if ({bcd_tens, bcd_ones} !== 8'h20 || done !== 1'b1) bad++;
      if (tick === 1'b1) ticks++;
    end
    check("hold_20_bad_cycles", 32'(bad), 32'd0);
    check("hold_20_ticks", 32'(ticks), 32'd0);
`endif

    // 3. down run from 20 while dir toggles
    press_clear();
    dir = 1'b1;
    @(negedge CLOCK_50);
    check("idle_tracks_dir", 32'({bcd_tens, bcd_ones, running}), 32'h040);
    press_start();
    check("down_running", 32'(running), 32'd1);
    seen10 = 0;
    reached00 = 0;
    for (int i = 0; i < 300 && !reached00; i++) begin
      dir = 1'($urandom);
      @(negedge CLOCK_50);
      if ({bcd_tens, bcd_ones} === 8'h10) seen10 = 1;
      if ({bcd_tens, bcd_ones} === 8'h00) reached00 = 1;
    end
    dir = 1'b0;
    check("down_saw_10", 32'(seen10), 32'd1);
    check("down_reached_00", 32'(reached00), 32'd1);
`ifndef AUTO_RELOAD_EN
    @(negedge CLOCK_50);
    check("down_done", 32'({running, done}), 32'h1);
`endif

    // 4. pause at 07 with the prescaler at 2, then resume
    press_clear();
    press_start();
    wait_digits(8'h07, 200);
    @(negedge CLOCK_50);
    start_stop = 1'b1;
    @(negedge CLOCK_50);
    start_stop = 1'b0;
    check("paused", 32'({bcd_tens, bcd_ones, running}), 32'h0E);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK_50);
      if (tick === 1'b1) ticks++;
    end
    check("no_tick_paused", 32'(ticks), 32'd0);
    check("digits_paused", 32'({bcd_tens, bcd_ones}), 32'h07);
    start_stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_50);
      start_stop = 1'b0;
      rsm[i] = tick;
    end
    check("resume_tick_timing", 32'(rsm), 32'h4);
    check("resume_07_08", 32'({bcd_tens, bcd_ones}), 32'h08);

    // 5. clear beats start_stop in the same cycle; KEY0 mid-run
    wait_digits(8'h13, 200);
    clear = 1'b1;
    start_stop = 1'b1;
    @(negedge CLOCK_50);
    clear = 1'b0;
    start_stop = 1'b0;
    check("clear_priority", 32'({bcd_tens, bcd_ones, running, done}), 32'h0);
    press_start();
    repeat (9) @(negedge CLOCK_50);
    KEY0 = 1'b1;
    @(negedge CLOCK_50);
    KEY0 = 1'b0;
    check("key0_mid_run", 32'({bcd_tens, bcd_ones, tick, running, done}), 32'h0);

    // Randomized phase against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0) start_stop = ~start_stop;
      if ($urandom_range(63) == 0) clear = ~clear;
      if ($urandom_range(7) == 0) dir = ~dir;
      KEY0 = ($urandom_range(999) == 0);
      @(negedge CLOCK_50);
    end
    KEY0 = 1'b0;
    @(negedge CLOCK_50);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
